// File: rtl/piece_ctrl_pkg.sv
// Shared definitions for the falling-piece controller: piece encodings,
// board width, spawn defaults and the controller state enum.
package piece_ctrl_pkg;

   typedef enum logic [2:0] {
      PC_I = 3'd0,
      PC_J = 3'd1,
      PC_L = 3'd2,
      PC_O = 3'd3,
      PC_S = 3'd4,
      PC_T = 3'd5,
      PC_Z = 3'd6
   } piece_e;

   localparam int unsigned BOARD_W         = 10;
   localparam int unsigned SPAWN_X_DEF     = BOARD_W / 2 - 2;
   localparam int unsigned SPAWN_Y_DEF     = 0;
   localparam logic [7:0]  LFSR_SEED_DEF   = 8'hA5;
   localparam int unsigned REF_TIMEOUT_DEF = 255;

   typedef enum logic [2:0] {
      ST_SPAWN    = 3'd0,
      ST_CHECK    = 3'd1,
      ST_FALL     = 3'd2,
      ST_LOCK     = 3'd3,
      ST_WAIT_REF = 3'd4,
      ST_GAMEOVER = 3'd5
   } state_e;

   // Raw value 7 has no piece, so it folds onto the I piece.
   function automatic logic [2:0] map_candidate(input logic [2:0] raw);
      return (raw == 3'd7) ? 3'd0 : raw;
   endfunction

endpackage

// File: rtl/piece_ctrl_gen.sv
// Next-piece generator: free-running 8-bit Fibonacci LFSR (taps 8,6,5,4)
// whose low three bits are folded onto the seven piece types.
module piece_ctrl_gen
   import piece_ctrl_pkg::*;
#(
   parameter logic [7:0] SEED = LFSR_SEED_DEF
) (
   input  logic       clk,
   input  logic       rstn,
   output logic [2:0] cand_o
);

   logic [7:0] lfsr_q;
   logic [7:0] lfsr_d;

   always_comb begin
      lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         lfsr_q <= SEED;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign cand_o = map_candidate(lfsr_q[2:0]);

endmodule

// File: rtl/piece_ctrl.sv
// Falling-piece controller: spawns pieces, applies moves and gravity gated by
// the board's enable flags, and hands locked pieces to the board for commit.
module piece_ctrl
   import piece_ctrl_pkg::*;
#(
   parameter int unsigned SPAWN_X     = SPAWN_X_DEF,
   parameter int unsigned SPAWN_Y     = SPAWN_Y_DEF,
   parameter logic [7:0]  LFSR_SEED   = LFSR_SEED_DEF,
   parameter int unsigned REF_TIMEOUT = REF_TIMEOUT_DEF
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        mv_left_i,
   input  logic        mv_right_i,
   input  logic        mv_rot_i,
   input  logic        mv_down_i,
   input  logic        tick_i,
   input  logic        el_i,
   input  logic        er_i,
   input  logic        eu_i,
   input  logic        ed_i,
   input  logic        overflow_i,
   input  logic        refresh_done_i,
   output logic [4:0]  x_o,
   output logic [4:0]  y_o,
   output logic [2:0]  type_o,
   output logic [1:0]  dir_o,
   output logic [2:0]  next_type_o,
   output logic        refresh_o,
   output logic        active_o,
   output logic        game_over_o,
   output logic        ref_err_o,
   output logic [15:0] pieces_o,
   output logic [2:0]  state_o
);

   localparam logic [15:0] TIMEOUT_LAST = 16'(REF_TIMEOUT - 1);

   state_e      state_q, state_d;
   logic [4:0]  x_q, x_d;
   logic [4:0]  y_q, y_d;
   logic [2:0]  type_q, type_d;
   logic [1:0]  dir_q, dir_d;
   logic [2:0]  next_q, next_d;
   logic [15:0] pieces_q, pieces_d;
   logic [15:0] wcnt_q, wcnt_d;
   logic        err_q, err_d;
   logic [2:0]  cand;

   piece_ctrl_gen #(.SEED(LFSR_SEED)) u_gen (
      .clk    (clk),
      .rstn   (rstn),
      .cand_o (cand)
   );

   // Commit handshake: refresh_o pulses for the single LOCK cycle; the board
   // answers with a one-cycle refresh_done_i, honoured only in WAIT_REF.
   always_comb begin
      state_d  = state_q;
      x_d      = x_q;
      y_d      = y_q;
      type_d   = type_q;
      dir_d    = dir_q;
      next_d   = next_q;
      pieces_d = pieces_q;
      wcnt_d   = wcnt_q;
      err_d    = err_q;
      case (state_q)
         ST_SPAWN: begin
            x_d     = 5'(SPAWN_X);
            y_d     = 5'(SPAWN_Y);
            dir_d   = 2'd0;
            type_d  = next_q;
            next_d  = cand;
            state_d = ST_CHECK;
         end
         ST_CHECK: begin
            state_d = overflow_i ? ST_GAMEOVER : ST_FALL;
         end
         ST_FALL: begin
            // One action per cycle; lower-priority pulses are dropped.
            if (tick_i || mv_down_i) begin
               if (ed_i) begin
                  y_d = y_q + 5'd1;
               end else begin
                  state_d = ST_LOCK;
               end
            end else if (mv_rot_i) begin
               if (eu_i) dir_d = dir_q + 2'd1;
            end else if (mv_left_i) begin
               if (el_i) x_d = x_q - 5'd1;
            end else if (mv_right_i) begin
               if (er_i) x_d = x_q + 5'd1;
            end
         end
         ST_LOCK: begin
            if (pieces_q != 16'hFFFF) pieces_d = pieces_q + 16'd1;
            wcnt_d  = 16'd0;
            state_d = ST_WAIT_REF;
         end
         ST_WAIT_REF: begin
            if (refresh_done_i) begin
               state_d = ST_SPAWN;
            end else if (wcnt_q == TIMEOUT_LAST) begin
               err_d   = 1'b1;
               state_d = ST_SPAWN;
            end else begin
               wcnt_d = wcnt_q + 16'd1;
            end
         end
         ST_GAMEOVER: begin
            state_d = ST_GAMEOVER;
         end
         default: begin
            state_d = ST_SPAWN;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q  <= ST_SPAWN;
         x_q      <= 5'(SPAWN_X);
         y_q      <= 5'(SPAWN_Y);
         type_q   <= 3'd0;
         dir_q    <= 2'd0;
         next_q   <= 3'd0;
         pieces_q <= 16'd0;
         wcnt_q   <= 16'd0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         x_q      <= x_d;
         y_q      <= y_d;
         type_q   <= type_d;
         dir_q    <= dir_d;
         next_q   <= next_d;
         pieces_q <= pieces_d;
         wcnt_q   <= wcnt_d;
         err_q    <= err_d;
      end
   end

   assign x_o         = x_q;
   assign y_o         = y_q;
   assign type_o      = type_q;
   assign dir_o       = dir_q;
   assign next_type_o = next_q;
   assign pieces_o    = pieces_q;
   assign ref_err_o   = err_q;
   assign refresh_o   = (state_q == ST_LOCK);
   assign active_o    = (state_q == ST_FALL);
   assign game_over_o = (state_q == ST_GAMEOVER);
   assign state_o     = state_q;

endmodule

// File: tb/tb_piece_ctrl.sv
// Bench for piece_ctrl: directed table plus corner sequences, then random
// traffic, all compared each cycle against a behavioural model.
module tb_piece_ctrl;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        mv_left = 1'b0, mv_right = 1'b0, mv_rot = 1'b0, mv_down = 1'b0, tick = 1'b0;
   logic        el = 1'b1, er = 1'b1, eu = 1'b1, ed = 1'b1;
   logic        overflow = 1'b0, refresh_done = 1'b0;
   logic [4:0]  x_o, y_o;
   logic [2:0]  type_o, next_type_o, state_o;
   logic [1:0]  dir_o;
   logic        refresh_o, active_o, game_over_o, ref_err_o;
   logic [15:0] pieces_o;

   int total = 0;
   int bad   = 0;

   piece_ctrl dut (
      .clk(clk), .rstn(rstn),
      .mv_left_i(mv_left), .mv_right_i(mv_right), .mv_rot_i(mv_rot),
      .mv_down_i(mv_down), .tick_i(tick),
      .el_i(el), .er_i(er), .eu_i(eu), .ed_i(ed),
      .overflow_i(overflow), .refresh_done_i(refresh_done),
      .x_o(x_o), .y_o(y_o), .type_o(type_o), .dir_o(dir_o),
      .next_type_o(next_type_o), .refresh_o(refresh_o), .active_o(active_o),
      .game_over_o(game_over_o), .ref_err_o(ref_err_o), .pieces_o(pieces_o),
      .state_o(state_o)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   localparam int PH_SPAWN = 0, PH_CHECK = 1, PH_FALL = 2, PH_LOCK = 3, PH_WAIT = 4, PH_OVER = 5;
   int         m_ph, m_x, m_y, m_type, m_dir, m_next, m_pieces, m_wait;
   logic       m_err;
   logic [7:0] m_lfsr;

   function automatic int cand_of(input logic [7:0] l);
      int v;
      v = int'(l) % 8;
      return (v == 7) ? 0 : v;
   endfunction

   task automatic model_edge();
      int c;
      if (!rstn) begin
         m_ph = PH_SPAWN; m_x = 3; m_y = 0; m_type = 0; m_dir = 0; m_next = 0;
         m_pieces = 0; m_wait = 0; m_err = 1'b0; m_lfsr = 8'hA5;
         return;
      end
      c = cand_of(m_lfsr);
      case (m_ph)
         PH_SPAWN: begin
            m_x = 3; m_y = 0; m_dir = 0; m_type = m_next; m_next = c; m_ph = PH_CHECK;
         end
         PH_CHECK: m_ph = overflow ? PH_OVER : PH_FALL;
         PH_FALL: begin
            if (tick || mv_down) begin
               if (ed) m_y = (m_y + 1) % 32; else m_ph = PH_LOCK;
            end else if (mv_rot) begin
               if (eu) m_dir = (m_dir + 1) % 4;
            end else if (mv_left) begin
               if (el) m_x = (m_x + 31) % 32;
            end else if (mv_right) begin
               if (er) m_x = (m_x + 1) % 32;
            end
         end
         PH_LOCK: begin
            if (m_pieces < 65535) m_pieces++;
            m_wait = 0;
            m_ph = PH_WAIT;
         end
         PH_WAIT: begin
            m_wait++;
            if (refresh_done) m_ph = PH_SPAWN;
            else if (m_wait == 255) begin m_err = 1'b1; m_ph = PH_SPAWN; end
         end
         default: ;
      endcase
      m_lfsr = {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
   endtask

   function automatic logic [63:0] model_vec();
      return {26'd0, 5'(m_x), 5'(m_y), 3'(m_type), 2'(m_dir), 3'(m_next),
              (m_ph == PH_LOCK), (m_ph == PH_FALL), (m_ph == PH_OVER), m_err, 16'(m_pieces)};
   endfunction

   function automatic logic [63:0] dut_vec();
      return {26'd0, x_o, y_o, type_o, dir_o, next_type_o,
              refresh_o, active_o, game_over_o, ref_err_o, pieces_o};
   endfunction

   // ---------------- checking / driving ----------------
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, expected %0h (state_o=%0d)", name, act, exp, state_o);
      end
   endtask

   task automatic step(input string name);
      @(posedge clk);
      model_edge();
      #1;
      chk(name, dut_vec(), model_vec());
      mv_left = 0; mv_right = 0; mv_rot = 0; mv_down = 0; tick = 0; refresh_done = 0;
   endtask

   typedef struct {
      logic tk, dn, rt, lf, rg;
      logic e_l, e_r, e_u, e_d;
      int   ex, ey, edir;
   } vec_t;

   vec_t tbl[14];

   initial begin
      tbl[0]  = '{0,0,0,0,1, 1,1,1,1, 4,0,0};
      tbl[1]  = '{0,0,0,0,1, 1,1,1,1, 5,0,0};
      tbl[2]  = '{0,0,0,0,1, 1,1,1,1, 6,0,0};
      tbl[3]  = '{0,0,0,0,1, 1,1,1,1, 7,0,0};
      tbl[4]  = '{0,0,0,0,1, 1,0,1,1, 7,0,0};
      tbl[5]  = '{0,0,0,1,0, 1,0,1,1, 6,0,0};
      tbl[6]  = '{1,0,1,0,0, 1,1,1,1, 6,1,0};
      tbl[7]  = '{0,0,1,0,0, 1,1,1,1, 6,1,1};
      tbl[8]  = '{0,0,1,0,0, 1,1,1,1, 6,1,2};
      tbl[9]  = '{0,0,1,0,0, 1,1,1,1, 6,1,3};
      tbl[10] = '{0,0,1,0,0, 1,1,1,1, 6,1,0};
      tbl[11] = '{0,1,0,1,0, 1,1,1,1, 6,2,0};
      tbl[12] = '{0,0,0,1,1, 1,1,1,1, 5,2,0};
      tbl[13] = '{0,0,1,0,0, 1,1,0,1, 5,2,0};

      // reset and first spawn
      rstn = 0;
      step("reset0");
      step("reset1");
      chk("reset_state", dut_vec(), {26'd0, 5'd3, 5'd0, 3'd0, 2'd0, 3'd0, 4'b0000, 16'd0});
      rstn = 1;
      step("spawn");
      step("check");
      chk("first_fall", dut_vec(), {26'd0, 5'd3, 5'd0, 3'd0, 2'd0, 3'd5, 4'b0100, 16'd0});

      // moves and priority
      for (int i = 0; i < 14; i++) begin
         tick = tbl[i].tk; mv_down = tbl[i].dn; mv_rot = tbl[i].rt;
         mv_left = tbl[i].lf; mv_right = tbl[i].rg;
         el = tbl[i].e_l; er = tbl[i].e_r; eu = tbl[i].e_u; ed = tbl[i].e_d;
         step($sformatf("tbl_model_%0d", i));
         chk($sformatf("tbl_%0d", i), {52'd0, x_o, y_o, dir_o},
             {52'd0, 5'(tbl[i].ex), 5'(tbl[i].ey), 2'(tbl[i].edir)});
      end
      el = 1; er = 1; eu = 1;

      // lock, commit handshake, respawn with the previewed type
      refresh_done = 1;
      step("stray_done_in_fall");
      chk("stray_done_ignored", {63'd0, active_o}, 64'd1);
      ed = 0; tick = 1;
      step("lock");
      chk("lock_pulse", {44'd0, refresh_o, active_o, pieces_o, x_o, y_o},
          {44'd0, 1'b1, 1'b0, 16'd0, 5'd5, 5'd2});
      step("wait1");
      chk("refresh_one_cycle", {47'd0, refresh_o, pieces_o}, {47'd0, 1'b0, 16'd1});
      for (int i = 2; i <= 4; i++) step($sformatf("wait%0d", i));
      chk("wait_hold", {49'd0, x_o, y_o, type_o, dir_o}, {49'd0, 5'd5, 5'd2, 3'd0, 2'd0});
      ed = 1; refresh_done = 1;
      step("done");
      step("spawn2");
      chk("spawn2_type", {51'd0, type_o, x_o, y_o}, {51'd0, 3'd5, 5'd3, 5'd0});
      step("fall2");

      // refresh_done timeout
      ed = 0; tick = 1;
      step("lock2");
      step("wait_t0");
      for (int i = 0; i < 254; i++) step("wait_t");
      chk("no_err_before_timeout", {62'd0, ref_err_o, refresh_o}, 64'd0);
      step("timeout");
      chk("ref_err_set", {61'd0, ref_err_o, active_o, game_over_o}, {61'd0, 3'b100});
      ed = 1;

      // game over in CHECK, then freeze, then reset
      overflow = 1;
      step("spawn3");
      step("check3");
      chk("game_over", {62'd0, game_over_o, active_o}, {62'd0, 2'b10});
      overflow = 0;
      for (int i = 0; i < 10; i++) begin
         mv_left = 1'($urandom_range(0, 1)); mv_right = 1'($urandom_range(0, 1));
         mv_rot = 1'($urandom_range(0, 1)); mv_down = 1'($urandom_range(0, 1));
         tick = 1'($urandom_range(0, 1)); refresh_done = 1'($urandom_range(0, 1));
         step("frozen");
      end
      chk("frozen_pos", {50'd0, x_o, y_o, dir_o, pieces_o[1:0], game_over_o, ref_err_o},
          {50'd0, 5'd3, 5'd0, 2'd0, 2'd2, 1'b1, 1'b1});
      rstn = 0;
      step("reset_go");
      chk("reset_clears", {44'd0, game_over_o, ref_err_o, active_o, pieces_o, type_o},
          {44'd0, 3'b000, 16'd0, 3'd0});
      rstn = 1;

      // random traffic against the model
      for (int n = 0; n < 4000; n++) begin
         mv_left  = ($urandom_range(0, 3) == 0);
         mv_right = ($urandom_range(0, 3) == 0);
         mv_rot   = ($urandom_range(0, 3) == 0);
         mv_down  = ($urandom_range(0, 5) == 0);
         tick     = ($urandom_range(0, 5) == 0);
         el = ($urandom_range(0, 3) != 0);
         er = ($urandom_range(0, 3) != 0);
         eu = ($urandom_range(0, 3) != 0);
         ed = ($urandom_range(0, 4) != 0);
         overflow     = ($urandom_range(0, 15) == 0);
         refresh_done = ($urandom_range(0, 11) == 0);
         rstn = !(($urandom_range(0, 299) == 0) || (m_ph == PH_OVER && $urandom_range(0, 7) == 0));
         step("random");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
